// File: rtl/seg7_pkg.sv
// Shared state encodings and default timing constants for the button conditioner.
package seg7_pkg;

  localparam int CNT_W = 24;

  localparam int DEFAULT_N_BTN           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 512;
  localparam int DEFAULT_REPEAT_DELAY    = 5_000_000;
  localparam int DEFAULT_REPEAT_RATE     = 2_000_000;
  localparam logic [3:0] DEFAULT_REPEAT_MASK = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PRESS_WAIT   = 3'd1,
    S_HELD         = 3'd2,
    S_REPEAT       = 3'd3,
    S_RELEASE_WAIT = 3'd4
  } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM with a
// single shared counter, and registered level/pulse outputs.
module btn_channel
  import seg7_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int   REPEAT_RATE     = DEFAULT_REPEAT_RATE,
  parameter logic REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync_reg;
  logic             sync;
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             pulse_reg, pulse_next;
  logic             release_reg, release_next;

  assign sync = sync_reg[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg    <= '0;
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      pulse_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], btn_raw};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      pulse_reg   <= pulse_next;
      release_reg <= release_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    pulse_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        level_next = 1'b0;
        if (sync) begin
          state_next = S_PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!sync) begin
          state_next = S_IDLE;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = S_HELD;
          cnt_next   = '0;
          level_next = 1'b1;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_HELD: begin
        // Non-repeating channels park here with the counter frozen.
        if (!sync) begin
          state_next = S_RELEASE_WAIT;
          cnt_next   = '0;
        end else if (REPEAT_EN) begin
          if (cnt_reg == DELAY_LAST) begin
            state_next = S_REPEAT;
            cnt_next   = '0;
            pulse_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S_REPEAT: begin
        if (!sync) begin
          state_next = S_RELEASE_WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == RATE_LAST) begin
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_RELEASE_WAIT: begin
        // A bounce back to 1 returns to HELD and restarts the repeat delay.
        if (sync) begin
          state_next = S_HELD;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next   = S_IDLE;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign level         = level_reg;
  assign press_pulse   = pulse_reg;
  assign release_pulse = release_reg;

endmodule

// File: rtl/button_conditioner.sv
// Bank of independent debounced button channels with optional auto-repeat.
module button_conditioner
  import seg7_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(DEFAULT_REPEAT_MASK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (REPEAT_MASK[gi])
      ) u_chan (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw[gi]),
        .level         (btn_level[gi]),
        .press_pulse   (btn_pulse[gi]),
        .release_pulse (btn_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a run-length model.
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam logic [N-1:0] MASK = 4'b1100;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_pulse, btn_release;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: delayed input samples plus per-channel run lengths.
  logic [N-1:0] m_s1, m_s2, m_level, exp_pulse, exp_release, prev_pulse;
  int run_len [N];
  int hold_len[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; exp_pulse = '0; exp_release = '0;
    for (int i = 0; i < N; i++) begin
      run_len[i] = 0;
      hold_len[i] = 0;
    end
  endtask

  // Accept a change after D+1 consecutive differing samples; repeat pulses at
  // RD samples after the press/re-entry, then every RR samples.
  task automatic model_step();
    logic s;
    exp_pulse = '0;
    exp_release = '0;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        s = m_s2[i];
        if (!m_level[i]) begin
          if (s) begin
            run_len[i]++;
            if (run_len[i] == D + 1) begin
              m_level[i] = 1'b1; exp_pulse[i] = 1'b1; run_len[i] = 0; hold_len[i] = 0;
            end
          end else run_len[i] = 0;
        end else begin
          if (!s) begin
            run_len[i]++;
            if (run_len[i] == D + 1) begin
              m_level[i] = 1'b0; exp_release[i] = 1'b1; run_len[i] = 0;
            end
          end else if (run_len[i] > 0) begin
            run_len[i] = 0; hold_len[i] = 0;
          end else begin
            hold_len[i]++;
            if (MASK[i] && (hold_len[i] == RD || (hold_len[i] > RD && (hold_len[i] - RD) % RR == 0)))
              exp_pulse[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("level_model",   32'(btn_level),   32'(m_level));
    chk("pulse_model",   32'(btn_pulse),   32'(exp_pulse));
    chk("release_model", 32'(btn_release), 32'(exp_release));
    chk("no_double_pulse",   32'(btn_pulse & prev_pulse),  32'd0);
    chk("pulse_and_release", 32'(btn_pulse & btn_release), 32'd0);
    prev_pulse = btn_pulse;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int left[N];
    model_reset();
    prev_pulse = '0;

    // Reset state
    settle(3);
    chk("reset_level",   32'(btn_level),   32'd0);
    chk("reset_pulse",   32'(btn_pulse),   32'd0);
    chk("reset_release", 32'(btn_release), 32'd0);
    reset = 1'b0;
    settle(2);

    // Clean press on channel 0, no repeat
    btn_raw[0] = 1'b1;
    begin
      int cnt0 = 0;
      for (int e = 1; e <= 30; e++) begin
        tick();
        cnt0 += int'(btn_pulse[0]);
        if (e == 6) chk("ch0_level_e6", 32'(btn_level[0]), 32'd0);
        if (e == 7) chk("ch0_pulse_e7", 32'(btn_pulse[0]), 32'd1);
        if (e >= 7) chk("ch0_level_held", 32'(btn_level[0]), 32'd1);
      end
      chk("ch0_pulse_count", 32'(cnt0), 32'd1);
    end
    btn_raw[0] = 1'b0;
    settle(10);

    // Bouncing channel 1 never accepted
    for (int e = 0; e < 20; e++) begin
      btn_raw[1] = (e % 2 == 0);
      tick();
      chk("ch1_no_pulse", 32'(btn_pulse[1]), 32'd0);
      chk("ch1_level_low", 32'(btn_level[1]), 32'd0);
    end
    btn_raw[1] = 1'b0;
    settle(10);
    chk("ch1_level_after", 32'(btn_level[1]), 32'd0);

    // Channel 2 press with auto-repeat, then release
    btn_raw[2] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      chk("ch2_repeat_pattern", 32'(btn_pulse[2]), 32'(e == 7 || (e >= 17 && (e - 17) % 3 == 0)));
    end
    btn_raw[2] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("ch2_release_edge", 32'(btn_release[2]), 32'(e == 7));
    end
    chk("ch2_level_released", 32'(btn_level[2]), 32'd0);

    // Channel 3 release bounce while HELD
    btn_raw[3] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk("ch3_pulse_pattern", 32'(btn_pulse[3]), 32'(e == 7 || (e >= 24 && (e - 24) % 3 == 0)));
      chk("ch3_no_release", 32'(btn_release[3]), 32'd0);
      if (e >= 7) chk("ch3_level_stays", 32'(btn_level[3]), 32'd1);
      if (e == 9)  btn_raw[3] = 1'b0;
      if (e == 11) btn_raw[3] = 1'b1;
    end
    btn_raw[3] = 1'b0;
    settle(12);

    // Asynchronous reset mid-REPEAT on channel 2
    btn_raw[2] = 1'b1;
    settle(20);
    chk("ch2_level_pre_reset", 32'(btn_level[2]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_level",   32'(btn_level),   32'd0);
    chk("async_reset_pulse",   32'(btn_pulse),   32'd0);
    chk("async_reset_release", 32'(btn_release), 32'd0);
    model_reset();
    settle(2);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("post_reset_press", 32'(btn_pulse[2]), 32'(e == 7));
    end
    btn_raw[2] = 1'b0;
    settle(12);

    // All four pressed on the same edge
    btn_raw = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("all_pulse", 32'(btn_pulse), (e == 7) ? 32'hF : 32'h0);
    end
    btn_raw = '0;
    settle(12);

    // Random bouncing on all channels
    for (int i = 0; i < N; i++) left[i] = int'($urandom_range(1, 12));
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          left[i] = int'($urandom_range(1, 24));
        end else left[i]--;
      end
      tick();
    end
    btn_raw = '0;
    settle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
